// File: rtl/fft_spi_controller.sv
// fft_spi_controller: SPI mode-0 initiator that frames each transfer with spi_rst.
// Ports: i_clk, i_reset (sync, active-high), i_start, i_tx_frame -> o_busy,
//        o_done, o_rx_frame; SPI side o_sck, o_copi, i_cipo, o_spi_rst.
module fft_spi_controller #(
    parameter int FRAME_BITS = 4096,
    parameter int CLK_DIV    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_tx_frame,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [FRAME_BITS-1:0] o_rx_frame,
    output logic                  o_sck,
    output logic                  o_copi,
    input  logic                  i_cipo,
    output logic                  o_spi_rst
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        SHIFT
    } state_t;

    state_t                r_state;
    logic [DW-1:0]         r_div;
    logic [BW-1:0]         r_bit;
    logic [FRAME_BITS-1:0] r_tx_sr;
    logic [FRAME_BITS-1:0] r_rx_sr;
    logic [FRAME_BITS-1:0] r_rx_frame;
    logic                  r_sck;
    logic                  r_copi;
    logic                  r_spi_rst;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_tick;

    // sck toggles on the last clk of each half-period
    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_frame <= '0;
            r_sck      <= 1'b0;
            r_copi     <= 1'b0;
            r_spi_rst  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_div  <= '0;
                    r_bit  <= '0;
                    r_sck  <= 1'b0;
                    r_copi <= 1'b0;
                    if (i_start) begin
                        r_tx_sr   <= i_tx_frame;
                        r_busy    <= 1'b1;
                        r_spi_rst <= 1'b1;
                        r_state   <= PRE;
                    end
                end
                PRE: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_sck <= ~r_sck;
                        // falling edge of the reset pulse presents bit 0
                        if (r_sck) begin
                            r_spi_rst <= 1'b0;
                            r_copi    <= r_tx_sr[FRAME_BITS-1];
                            r_tx_sr   <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
                            r_state   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_sck <= ~r_sck;
                        if (!r_sck) begin
                            r_rx_sr <= {r_rx_sr[FRAME_BITS-2:0], i_cipo};
                        end else if (r_bit == BIT_LAST) begin
                            // last falling edge completes the frame
                            r_rx_frame <= r_rx_sr;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_copi     <= 1'b0;
                            r_bit      <= '0;
                            r_div      <= '0;
                            r_state    <= IDLE;
                        end else begin
                            r_copi  <= r_tx_sr[FRAME_BITS-1];
                            r_tx_sr <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rx_frame = r_rx_frame;
    assign o_sck      = r_sck;
    assign o_copi     = r_copi;
    assign o_spi_rst  = r_spi_rst;

endmodule

// File: tb/tb_fft_spi_controller.sv
// tb_fft_spi_controller: randomized frames against a peripheral-level model.
// Two instances: CLK_DIV=2 for framing/data, CLK_DIV=1 for back-to-back.
module tb_fft_spi_controller;
    localparam int N    = 8;
    localparam int H    = 2;
    localparam int LAT  = 2 * H * (N + 1);
    localparam int LAT1 = 2 * 1 * (N + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] tx = '0;
    logic         busy, done, sck, copi, spi_rst, cipo;
    logic [N-1:0] rx;

    logic         reset1 = 1'b1;
    logic         start1 = 1'b0;
    logic [N-1:0] tx1 = '0;
    logic         busy1, done1, sck1, copi1, spi_rst1;
    logic [N-1:0] rx1;

    logic [1:0]   cmode = 2'd0;
    logic [N-1:0] pword = '0;
    int           pidx = 0;

    fft_spi_controller #(.FRAME_BITS(N), .CLK_DIV(H)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_tx_frame(tx), .o_busy(busy), .o_done(done),
        .o_rx_frame(rx), .o_sck(sck), .o_copi(copi),
        .i_cipo(cipo), .o_spi_rst(spi_rst)
    );

    fft_spi_controller #(.FRAME_BITS(N), .CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_reset(reset1), .i_start(start1),
        .i_tx_frame(tx1), .o_busy(busy1), .o_done(done1),
        .o_rx_frame(rx1), .o_sck(sck1), .o_copi(copi1),
        .i_cipo(copi1), .o_spi_rst(spi_rst1)
    );

    // peripheral model: 0 loopback, 1 shift out pword MSB-first, 2 stuck high
    always_comb begin
        cipo = 1'b1;
        if (cmode == 2'd0) cipo = copi;
        else if (cmode == 2'd1) cipo = (pidx < N) ? pword[N-1-pidx] : 1'b0;
    end

    int   rises = 0;
    int   rst_rises = 0;
    int   done_cnt = 0;
    logic first_rst = 1'b0;
    logic sck_q = 1'b0;
    logic copi_q[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (sck && !sck_q) begin
            if (rises == 0) first_rst = spi_rst;
            rises++;
            if (spi_rst) rst_rises++;
            else begin
                copi_q.push_back(copi);
                pidx++;
            end
        end
        if (spi_rst) pidx = 0;
        sck_q = sck;
    end

    int   rises1 = 0;
    int   rst_rises1 = 0;
    logic sck1_q = 1'b0;
    int   dq1[$];

    always @(negedge clk) begin
        if (done1) dq1.push_back(cyc);
        if (sck1 && !sck1_q) begin
            rises1++;
            if (spi_rst1) rst_rises1++;
        end
        sck1_q = sck1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [N-1:0] tx_v,
                             output int lat, output int bcnt);
        int k;
        step();
        rises = 0;
        rst_rises = 0;
        copi_q.delete();
        tx = tx_v;
        start = 1'b1;
        step();
        start = 1'b0;
        k = cyc;
        lat = -1;
        bcnt = 0;
        for (int i = 0; i < 4 * LAT; i++) begin
            if (done) begin
                lat = cyc - k;
                break;
            end
            if (busy) bcnt++;
            step();
        end
    endtask

    function automatic logic [N-1:0] copi_word();
        logic [N-1:0] w = '0;
        for (int j = 0; j < copi_q.size(); j++) w = {w[N-2:0], copi_q[j]};
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        reset1 = 1'b1;
        repeat (3) step();
        checks++;
        if ({sck, copi, spi_rst, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 00000", {sck, copi, spi_rst, busy, done});
        end
        checks++;
        if (rx !== '0) begin
            errors++;
            $display("FAIL reset_rx got %h exp 00", rx);
        end
        checks++;
        if ({sck1, copi1, spi_rst1, busy1, done1} !== 5'b0 || rx1 !== '0) begin
            errors++;
            $display("FAIL reset_dut1 got %b/%h exp 0",
                     {sck1, copi1, spi_rst1, busy1, done1}, rx1);
        end
        reset = 1'b0;
        reset1 = 1'b0;
        step();
    endtask

    task automatic test_loopback();
        int lat, bcnt, d0;
        logic [N-1:0] v;
        cmode = 2'd0;
        for (int t = 0; t < 5; t++) begin
            v = (t == 0) ? 8'hA5 : N'($urandom);
            d0 = done_cnt;
            run_frame(v, lat, bcnt);
            repeat (4) step();
            checks++;
            if (rx !== v) begin
                errors++;
                $display("FAIL loop_rx got %h exp %h", rx, v);
            end
            checks++;
            if (lat != LAT || bcnt != LAT) begin
                errors++;
                $display("FAIL loop_timing lat %0d busy %0d exp %0d", lat, bcnt, LAT);
            end
            checks++;
            if (rises != N + 1 || rst_rises != 1 || first_rst !== 1'b1) begin
                errors++;
                $display("FAIL loop_sck rises %0d rst %0d first %b exp %0d 1 1",
                         rises, rst_rises, first_rst, N + 1);
            end
            checks++;
            if (copi_q.size() != N || copi_word() !== v) begin
                errors++;
                $display("FAIL loop_copi got %h (%0d bits) exp %h",
                         copi_word(), copi_q.size(), v);
            end
            checks++;
            if (done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL loop_done_pulse got %0d exp 1", done_cnt - d0);
            end
        end
    endtask

    task automatic test_cipo_high();
        int lat, bcnt;
        cmode = 2'd2;
        run_frame(8'h00, lat, bcnt);
        checks++;
        if (rx !== 8'hFF) begin
            errors++;
            $display("FAIL high_rx got %h exp ff", rx);
        end
        checks++;
        if (copi_q.size() != N || copi_word() !== 8'h00) begin
            errors++;
            $display("FAIL high_copi got %h exp 00", copi_word());
        end
        cmode = 2'd0;
    endtask

    task automatic test_periph();
        int lat, bcnt;
        logic [N-1:0] v;
        cmode = 2'd1;
        for (int t = 0; t < 4; t++) begin
            pword = N'($urandom);
            v = N'($urandom);
            run_frame(v, lat, bcnt);
            checks++;
            if (rx !== pword || lat != LAT) begin
                errors++;
                $display("FAIL periph_rx got %h lat %0d exp %h lat %0d",
                         rx, lat, pword, LAT);
            end
            checks++;
            if (copi_word() !== v) begin
                errors++;
                $display("FAIL periph_copi got %h exp %h", copi_word(), v);
            end
        end
        cmode = 2'd0;
    endtask

    task automatic test_busy_start();
        int k, lat, d0;
        logic [N-1:0] a;
        a = N'($urandom);
        step();
        tx = a;
        start = 1'b1;
        step();
        start = 1'b0;
        k = cyc;
        d0 = done_cnt;
        lat = -1;
        repeat (10) step();
        tx = ~a;
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        for (int i = 0; i < 4 * LAT; i++) begin
            if (done) begin
                lat = cyc - k;
                break;
            end
            step();
        end
        repeat (3 * LAT) step();
        checks++;
        if (done_cnt - d0 != 1 || lat != LAT) begin
            errors++;
            $display("FAIL busy_start dones %0d lat %0d exp 1 %0d",
                     done_cnt - d0, lat, LAT);
        end
        checks++;
        if (rx !== a) begin
            errors++;
            $display("FAIL busy_start_rx got %h exp %h", rx, a);
        end
    endtask

    task automatic test_abort();
        int lat, bcnt, d0;
        logic [N-1:0] b;
        run_frame(8'h3C, lat, bcnt);
        step();
        copi_q.delete();
        tx = 8'hC3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4 * LAT; i++) begin
            if (copi_q.size() >= 4) break;
            step();
        end
        reset = 1'b1;
        step();
        checks++;
        if ({sck, copi, spi_rst, busy, done} !== 5'b0 || rx !== '0) begin
            errors++;
            $display("FAIL abort_state got %b rx %h exp 00000 rx 00",
                     {sck, copi, spi_rst, busy, done}, rx);
        end
        reset = 1'b0;
        d0 = done_cnt;
        repeat (2 * LAT) step();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done dones %0d busy %b exp 0 0",
                     done_cnt - d0, busy);
        end
        b = N'($urandom);
        run_frame(b, lat, bcnt);
        checks++;
        if (rx !== b || lat != LAT) begin
            errors++;
            $display("FAIL abort_restart got %h lat %0d exp %h lat %0d", rx, lat, b, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int c, s0, s1, f0;
        logic [N-1:0] v;
        v = N'($urandom);
        step();
        dq1.delete();
        rises1 = 0;
        rst_rises1 = 0;
        tx1 = v;
        start1 = 1'b1;
        c = cyc;
        for (int i = 0; i < 20 * LAT1; i++) begin
            if (dq1.size() >= 3) break;
            step();
        end
        start1 = 1'b0;
        repeat (4) step();
        f0 = (dq1.size() >= 1) ? dq1[0] - c : -1;
        s0 = (dq1.size() >= 2) ? dq1[1] - dq1[0] : -1;
        s1 = (dq1.size() >= 3) ? dq1[2] - dq1[1] : -1;
        checks++;
        if (dq1.size() != 3 || f0 != LAT1 + 1) begin
            errors++;
            $display("FAIL b2b_first dones %0d first %0d exp 3 %0d",
                     dq1.size(), f0, LAT1 + 1);
        end
        checks++;
        if (s0 != LAT1 + 1 || s1 != LAT1 + 1) begin
            errors++;
            $display("FAIL b2b_spacing got %0d %0d exp %0d", s0, s1, LAT1 + 1);
        end
        checks++;
        if (rst_rises1 != 3 || rises1 != 3 * (N + 1)) begin
            errors++;
            $display("FAIL b2b_sck rst %0d rises %0d exp 3 %0d",
                     rst_rises1, rises1, 3 * (N + 1));
        end
        checks++;
        if (rx1 !== v || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rx got %h busy %b exp %h 0", rx1, busy1, v);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_cipo_high();
        test_periph();
        test_busy_start();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fft_spi_controller.md
Name: fft_spi_controller

Overview:
- FPGA-side SPI controller (initiator) for the fft_spi peripheral protocol: generates sck, drives COPI, samples CIPO, and frames each transfer with the active-high peripheral reset.
- Shifts one FRAME_BITS-bit frame MSB-first out of tx_frame and simultaneously captures FRAME_BITS bits into rx_frame.
- Used for on-FPGA loopback/bring-up of the FFT link and as the board-level bench driver for fft_spi.
- Operates entirely on the system clock; sck is a divided, registered output.

Parameters:
- FRAME_BITS, 4096, bits per frame (>=2).
- CLK_DIV, 4, clk cycles per sck half-period (H, >=1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request a frame; accepted only in IDLE.
- tx_frame  input  FRAME_BITS  data to send; captured on the accept edge.
- busy  output  1  high from the accept edge until the done cycle.
- done  output  1  one-cycle pulse when a frame completes.
- rx_frame  output  FRAME_BITS  received frame; first received bit in the MSB; updated only at done.
- sck  output  1  SPI clock; idles low.
- copi  output  1  controller-to-peripheral data (fft_spi sdi).
- cipo  input  1  peripheral-to-controller data (fft_spi sdo).
- spi_rst  output  1  frame-start reset to the peripheral (fft_spi reset).

Behaviour:
- Reset values: sck=0, copi=0, spi_rst=0, busy=0, done=0, rx_frame=0; state IDLE; divider and bit counters 0.
- SPI mode 0:
  - copi changes only while sck is low, on the edge sck falls (or on the PRE->SHIFT edge for bit 0).
  - cipo is sampled into the rx shift register on the clk edge where sck goes 0->1.
- Divider: sck toggles every H=CLK_DIV clk cycles while in PRE or SHIFT; the divider is held at 0 in IDLE/DONE.
- States:
  - IDLE:
    - start=1 at edge k: load the tx shift register from tx_frame, busy<=1, spi_rst<=1, go PRE.
    - Otherwise hold: sck=0, copi=0.
  - PRE:
    - One full sck cycle with spi_rst=1 and copi=0: sck rises at k+H, falls at k+2H.
    - At edge k+2H: spi_rst<=0, copi<=tx_frame[FRAME_BITS-1], go SHIFT.
  - SHIFT, bit i in 0..FRAME_BITS-1:
    - sck rises at k+3H+2H*i: sample cipo.
    - sck falls at k+4H+2H*i: present copi for bit i+1, increment the bit counter.
    - After the falling edge of the last bit, go DONE.
  - DONE:
    - Taken at edge k+2H*(FRAME_BITS+1): rx_frame<=captured bits, done<=1 for exactly one cycle, busy<=0, copi<=0, return to IDLE.
- Latency: done is high in the cycle beginning 2*CLK_DIV*(FRAME_BITS+1) clk cycles after the accept edge.
- Bit counter width: $clog2(FRAME_BITS+1); terminal count compared exactly, no wrap.
- Boundary conditions:
  - start while busy: ignored; no queueing.
  - start held high: a new frame is accepted on the first IDLE cycle after done (done cycle + 1).
  - tx_frame changes mid-frame: no effect; the frame uses the captured copy.
  - reset mid-frame: abort immediately; all outputs return to reset values, no done pulse, rx_frame cleared.
  - CLK_DIV=1: sck = clk/2; all edge relations above still hold.

Test Plan:
- Loopback, FRAME_BITS=8, CLK_DIV=2, copi tied to cipo, tx_frame=8'hA5, start pulsed at edge k:
  - rx_frame=8'hA5; done high exactly at edge k+36; busy high for 36 cycles.
  - Exactly 9 sck rising edges, first with spi_rst=1.
- cipo forced to 1, FRAME_BITS=8, tx_frame=8'h00:
  - rx_frame=8'hFF; copi=0 at every sck rise.
- Against fft_spi (defaults), tx_frame=alternating 0x5A bytes, peripheral fft_output=incrementing bytes:
  - After done, rx_frame equals fft_output.
  - Peripheral fft_input equals tx_frame.
- start re-asserted during a busy frame, FRAME_BITS=8:
  - Ignored; only one done pulse; rx_frame reflects the first frame.
- Synchronous reset asserted at bit 4 of 8:
  - Next cycle: sck=0, spi_rst=0, busy=0, rx_frame=0; no done.
  - A subsequent start completes normally.
- start held high continuously, FRAME_BITS=8, CLK_DIV=1:
  - Back-to-back frames; each done spaced 18+1 cycles apart.
  - Each frame preceded by one spi_rst sck pulse.
